press_duration_classifier: RTL and testbench
============================================

Name: press_duration_classifier

Overview:
Consumes the single-cycle rise/fall pulses produced by the synchronous edge detector on a button line. Measures press duration in clk cycles and classifies each press:
- glitch (discarded)
- short press
- long press, with auto-repeat while held and a release event
All outputs are registered, in the clk domain, and feed the control FSMs downstream.

Parameters:
CNT_W, 20, width of duration counter and press_len.
MIN_TICKS, 1000, minimum duration accepted as a press; shorter presses are dropped as glitches.
LONG_TICKS, 500000, duration at which a press becomes long.
REPEAT_TICKS, 100000, auto-repeat period while long-held.
Legal range: 1 <= MIN_TICKS < LONG_TICKS < 2^CNT_W-1 and REPEAT_TICKS >= 1. Out-of-range values are unsupported.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous reset, active-high.
rise  in  1  1-cycle pulse: button pressed.
fall  in  1  1-cycle pulse: button released.
short_press  out  1  1-cycle pulse: release with MIN_TICKS <= D < LONG_TICKS.
long_press  out  1  1-cycle pulse: press reached LONG_TICKS.
repeat_tick  out  1  1-cycle pulse every REPEAT_TICKS while long-held.
long_release  out  1  1-cycle pulse: release after a long press.
hold_active  out  1  level: high while in LONG_HELD.
press_len  out  CNT_W  duration D of the last accepted press; holds until the next accepted press.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, rep_cnt=0.
  - All outputs 0, including press_len.
  - rst has priority over all inputs and applies mid-press; a fall arriving after reset in IDLE is ignored.
- Pulse outputs default to 0 every cycle; each asserts for exactly 1 cycle, after the edge that decides it.
- Duration D is defined as follows:
  - The edge sampling rise in IDLE loads cnt=1.
  - Each later edge in PRESSED/LONG_HELD without fall increments cnt, saturating at 2^CNT_W-1.
  - At the edge sampling fall, D = current cnt.
  - Consequence: rise sampled at edge E0 and fall sampled at E10 gives D=10.
- IDLE:
  - rise: go to PRESSED, cnt<=1, rep_cnt<=0.
  - fall: ignored. rise and fall in the same cycle: rise wins.
- PRESSED:
  - fall sampled:
    - D < MIN_TICKS: no output, press_len unchanged.
    - Otherwise: short_press=1, press_len<=D.
    - Return to IDLE in either case.
  - No fall and cnt == LONG_TICKS-1: cnt<=LONG_TICKS, long_press=1, hold_active<=1, rep_cnt<=0, go to LONG_HELD.
  - Otherwise: cnt<=cnt+1.
  - rise is ignored (fall has priority if both are present).
- LONG_HELD:
  - fall sampled: long_release=1, press_len<=D (saturated value if the counter saturated), hold_active<=0, go to IDLE. No repeat_tick on this edge, even if one was due.
  - Else:
    - cnt increments (saturating) and rep_cnt<=rep_cnt+1.
    - When rep_cnt+1 == REPEAT_TICKS: repeat_tick=1 and rep_cnt<=0.
    - Repeats therefore occur at cnt = LONG_TICKS + n*REPEAT_TICKS, n>=1, and continue indefinitely, including after cnt saturates.
  - rise is ignored.
- Latency: every classification output is valid the cycle after the edge that samples the deciding input; no combinational input-to-output paths.
- Widths: rep_cnt is CNT_W bits; all comparisons are unsigned.

Test Plan:
Bench parameters: CNT_W=8, MIN_TICKS=4, LONG_TICKS=20, REPEAT_TICKS=8.
1. Assert rst for 2 cycles with rise pulsing -> all outputs 0, press_len=0; first rise after reset starts a fresh press.
2. rise at E0, fall at E10 -> short_press high 1 cycle after E10, press_len=10, no other pulses, hold_active stays 0.
3. rise at E0, fall at E3 (D=3) -> no pulses, press_len keeps previous value (10). Then fall at E4 on a new press -> short_press, press_len=4.
4. rise at E0, hold, fall at E40:
   - long_press after E19 (cnt=20), hold_active=1.
   - repeat_tick after edges at cnt 28 and 36.
   - long_release after E40, press_len=40, hold_active=0.
5. Boundaries:
   - fall at E19 (D=19) -> short_press, press_len=19.
   - fall at E20 (D=20) -> long_press then long_release, press_len=20, no repeat.
   - fall at E36 -> no repeat on that edge, long_release, press_len=36.
6. rst at E25 while in LONG_HELD -> hold_active=0, outputs 0, press_len=0; fall at E30 ignored. Hold past E270 -> press_len saturates at 255 and repeats continue every 8 cycles.

Source files
------------

// File: rtl/press_duration_classifier.sv
// ============================================================================
// Module   : press_duration_classifier
// Purpose  : Times button presses from rise/fall pulses and classifies them as
//            glitch, short press or long press (with auto-repeat and release).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module press_duration_classifier #(
   parameter int CNT_W        = 20,
   parameter int MIN_TICKS    = 1000,
   parameter int LONG_TICKS   = 500000,
   parameter int REPEAT_TICKS = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rise,
   input  logic             fall,
   output logic             short_press,
   output logic             long_press,
   output logic             repeat_tick,
   output logic             long_release,
   output logic             hold_active,
   output logic [CNT_W-1:0] press_len
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_PRESSED   = 2'd1,
      S_LONG_HELD = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_MIN     = CNT_W'(MIN_TICKS);
   localparam logic [CNT_W-1:0] C_LONG    = CNT_W'(LONG_TICKS);
   localparam logic [CNT_W-1:0] C_LONG_M1 = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] C_REPEAT  = CNT_W'(REPEAT_TICKS);
   localparam logic [CNT_W-1:0] C_MAX     = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
   logic [CNT_W-1:0] press_len_q, press_len_d;
   logic             short_press_q, short_press_d;
   logic             long_press_q, long_press_d;
   logic             repeat_tick_q, repeat_tick_d;
   logic             long_release_q, long_release_d;
   logic             hold_active_q, hold_active_d;

   logic [CNT_W-1:0] cnt_sat_inc;
   logic [CNT_W-1:0] rep_inc;

   always_comb begin
      cnt_sat_inc    = (cnt_q == C_MAX) ? cnt_q : cnt_q + C_ONE;
      rep_inc        = rep_cnt_q + C_ONE;
      state_d        = state_q;
      cnt_d          = cnt_q;
      rep_cnt_d      = rep_cnt_q;
      press_len_d    = press_len_q;
      hold_active_d  = hold_active_q;
      short_press_d  = 1'b0;
      long_press_d   = 1'b0;
      repeat_tick_d  = 1'b0;
      long_release_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rise) begin
               state_d   = S_PRESSED;
               cnt_d     = C_ONE;
               rep_cnt_d = '0;
            end
         end
         S_PRESSED: begin
            if (fall) begin
               // Presses shorter than MIN_TICKS vanish without touching press_len.
               if (cnt_q >= C_MIN) begin
                  short_press_d = 1'b1;
                  press_len_d   = cnt_q;
               end
               state_d = S_IDLE;
            end else if (cnt_q == C_LONG_M1) begin
               cnt_d         = C_LONG;
               long_press_d  = 1'b1;
               hold_active_d = 1'b1;
               rep_cnt_d     = '0;
               state_d       = S_LONG_HELD;
            end else begin
               cnt_d = cnt_sat_inc;
            end
         end
         S_LONG_HELD: begin
            if (fall) begin
               long_release_d = 1'b1;
               press_len_d    = cnt_q;
               hold_active_d  = 1'b0;
               state_d        = S_IDLE;
            end else begin
               cnt_d = cnt_sat_inc;
               // Repeat timing runs on its own counter so it survives cnt saturating.
               if (rep_inc == C_REPEAT) begin
                  repeat_tick_d = 1'b1;
                  rep_cnt_d     = '0;
               end else begin
                  rep_cnt_d = rep_inc;
               end
            end
         end
         default: begin
            state_d       = S_IDLE;
            hold_active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         rep_cnt_q      <= '0;
         press_len_q    <= '0;
         hold_active_q  <= 1'b0;
         short_press_q  <= 1'b0;
         long_press_q   <= 1'b0;
         repeat_tick_q  <= 1'b0;
         long_release_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         rep_cnt_q      <= rep_cnt_d;
         press_len_q    <= press_len_d;
         hold_active_q  <= hold_active_d;
         short_press_q  <= short_press_d;
         long_press_q   <= long_press_d;
         repeat_tick_q  <= repeat_tick_d;
         long_release_q <= long_release_d;
      end
   end

   assign short_press  = short_press_q;
   assign long_press   = long_press_q;
   assign repeat_tick  = repeat_tick_q;
   assign long_release = long_release_q;
   assign hold_active  = hold_active_q;
   assign press_len    = press_len_q;

endmodule

`default_nettype wire

// File: tb/tb_press_duration_classifier.sv
// ============================================================================
// Module   : tb_press_duration_classifier
// Purpose  : Directed presses with hand-computed event lists checked by a
//            scoreboard monitor against the classifier outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_press_duration_classifier;

   localparam int CNT_W = 8;
   localparam int K_SHORT = 0, K_LONG = 1, K_REP = 2, K_LREL = 3;

   typedef struct {
      int         kind;
      int         cyc;
      logic [7:0] len;
      logic       hold;
   } ev_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             rise = 1'b0;
   logic             fall = 1'b0;
   logic             short_press, long_press, repeat_tick, long_release, hold_active;
   logic [CNT_W-1:0] press_len;

   int  cyc = 0;
   int  n_vec = 0;
   int  n_bad = 0;
   int  b;
   ev_t exp_q[$];

   press_duration_classifier #(
      .CNT_W(CNT_W), .MIN_TICKS(4), .LONG_TICKS(20), .REPEAT_TICKS(8)
   ) dut (
      .clk(clk), .rst(rst), .rise(rise), .fall(fall),
      .short_press(short_press), .long_press(long_press),
      .repeat_tick(repeat_tick), .long_release(long_release),
      .hold_active(hold_active), .press_len(press_len)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic exp_ev(input int kind, input int off, input int len, input bit hold);
      ev_t e;
      e.kind = kind; e.cyc = b + off; e.len = 8'(len); e.hold = hold;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // rise sampled at edge b, fall sampled at edge b+k; both=1 also raises fall at b.
   task automatic press(input int k, input bit both);
      rise = 1'b1; fall = both;
      @(negedge clk); rise = 1'b0; fall = 1'b0;
      repeat (k - 1) @(negedge clk);
      fall = 1'b1;
      @(negedge clk); fall = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic next_base();
      @(negedge clk);
      b = cyc + 1;
   endtask

   // Scoreboard monitor: every pulse pops and checks one expected event.
   always @(negedge clk) begin
      int  np;
      int  kind;
      ev_t e;
      np = $countones({short_press, long_press, repeat_tick, long_release});
      if (np != 0) begin
         n_vec++;
         kind = short_press ? K_SHORT : long_press ? K_LONG : repeat_tick ? K_REP : K_LREL;
         if (np > 1) begin
            n_bad++;
            $display("FAIL multi_pulse: %0d pulses at cycle %0d, expected 1", np, cyc);
         end else if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pulse: kind %0d at cycle %0d, expected none", kind, cyc);
         end else begin
            e = exp_q.pop_front();
            if (kind != e.kind || cyc != e.cyc || press_len != e.len || hold_active != e.hold) begin
               n_bad++;
               $display("FAIL event: got kind=%0d cyc=%0d len=%0d hold=%0d, expected kind=%0d cyc=%0d len=%0d hold=%0d",
                        kind, cyc, press_len, hold_active, e.kind, e.cyc, e.len, e.hold);
            end
         end
      end
   end

   initial begin
      // 1. reset with rise pulsing, then a stray fall in IDLE
      @(negedge clk); rst = 1'b1; rise = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; rise = 1'b0;
      check("reset_press_len", press_len, 0);
      check("reset_hold", hold_active, 0);
      check("reset_pulses", {short_press, long_press, repeat_tick, long_release}, 0);
      fall = 1'b1; @(negedge clk); fall = 1'b0;
      repeat (3) @(negedge clk);

      // 2. short press D=10
      next_base(); exp_ev(K_SHORT, 10, 10, 0); press(10, 0);
      check("short10_hold", hold_active, 0);

      // 3. glitch D=3, then minimum press D=4, then rise+fall together then fall at 5
      next_base(); press(3, 0);
      check("glitch_len_kept", press_len, 10);
      next_base(); exp_ev(K_SHORT, 4, 4, 0); press(4, 0);
      next_base(); exp_ev(K_SHORT, 5, 5, 0); press(5, 1);

      // 4. long press held to 40
      next_base();
      exp_ev(K_LONG, 19, 5, 1); exp_ev(K_REP, 27, 5, 1); exp_ev(K_REP, 35, 5, 1);
      exp_ev(K_LREL, 40, 40, 0);
      press(40, 0);
      check("long40_hold_after", hold_active, 0);

      // 5. boundaries
      next_base(); exp_ev(K_SHORT, 19, 19, 0); press(19, 0);
      next_base(); exp_ev(K_LONG, 19, 19, 1); exp_ev(K_LREL, 20, 20, 0); press(20, 0);
      next_base();
      exp_ev(K_LONG, 19, 20, 1); exp_ev(K_REP, 27, 20, 1); exp_ev(K_REP, 35, 20, 1);
      exp_ev(K_LREL, 36, 36, 0);
      press(36, 0);
      // fall lands exactly on a due repeat: release only
      next_base();
      exp_ev(K_LONG, 19, 36, 1); exp_ev(K_REP, 27, 36, 1); exp_ev(K_REP, 35, 36, 1);
      exp_ev(K_LREL, 43, 43, 0);
      press(43, 0);

      // 6. reset at E25 in LONG_HELD, fall at E30 ignored
      next_base(); exp_ev(K_LONG, 19, 43, 1);
      rise = 1'b1;
      @(negedge clk); rise = 1'b0;
      repeat (24) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check("midrst_hold", hold_active, 0);
      check("midrst_len", press_len, 0);
      repeat (4) @(negedge clk);
      fall = 1'b1;
      @(negedge clk); fall = 1'b0;
      repeat (5) @(negedge clk);
      check("after_rst_fall_len", press_len, 0);

      // saturation: hold to E300, counter pins at 255, repeats keep going
      next_base();
      exp_ev(K_LONG, 19, 0, 1);
      for (int n = 1; n <= 35; n++) exp_ev(K_REP, 19 + 8 * n, 0, 1);
      exp_ev(K_LREL, 300, 255, 0);
      press(300, 0);
      check("sat_len", press_len, 255);

      repeat (5) @(negedge clk);
      check("events_outstanding", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
